// File: rtl/angle_ctrl_pkg.sv
// rtl/angle_ctrl_pkg.sv - shared types, Q-format constants and saturation helper for angle_controller_nch
// Optional feature macro: ANGLE_CTRL_DEADBAND_EN (consumed in angle_ctrl_datapath).
package angle_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_MAP   = 5'b00010,
    S_SCALE = 5'b00100,
    S_LIMIT = 5'b01000,
    S_DONE  = 5'b10000
  } state_e;

  localparam int FRAC_W_DEF = 4;
  localparam int ONE        = 1 << FRAC_W_DEF;

  localparam logic [3:0] BIPOLAR_MASK_DEF = 4'b1110;
  localparam logic [3:0] FB_EN_MASK_DEF   = 4'b1100;
  localparam logic [3:0] FB_ADD_MASK_DEF  = 4'b1000;

  localparam int MAP_OFFSET_DEF = 500;
  localparam int RATE_LIMIT_DEF = 400;
  localparam int THR_MAX_DEF    = 1008;
  localparam int DEADBAND_DEF   = 16;

  // Clamp v into the signed range of a w-bit value; caller keeps the low w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/angle_ctrl_datapath.sv
// rtl/angle_ctrl_datapath.sv - shared single-channel map/scale/limit datapath with registered stage outputs
// Optional feature macro: ANGLE_CTRL_DEADBAND_EN (bipolar mapped-target deadband).
module angle_ctrl_datapath
  import angle_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int REC_W      = 8,
  parameter int RATE_W     = 16,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int SCALE_W    = 16,
  parameter int MAP_SHIFT  = 2,
  parameter int MAP_OFFSET = MAP_OFFSET_DEF,
  parameter int RATE_LIMIT = RATE_LIMIT_DEF,
  parameter int THR_MAX    = THR_MAX_DEF,
  parameter int DEADBAND   = DEADBAND_DEF,
  parameter logic [NUM_CH-1:0] BIPOLAR_MASK = NUM_CH'(BIPOLAR_MASK_DEF),
  parameter logic [NUM_CH-1:0] FB_EN_MASK   = NUM_CH'(FB_EN_MASK_DEF),
  parameter logic [NUM_CH-1:0] FB_ADD_MASK  = NUM_CH'(FB_ADD_MASK_DEF),
  parameter int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        us_clk,
  input  logic                        resetn,
  input  logic                        map_en,
  input  logic                        scale_en,
  input  logic [IDX_W-1:0]            idx,
  input  logic [NUM_CH*REC_W-1:0]     target_q,
  input  logic [NUM_CH*RATE_W-1:0]    actual_q,
  input  logic [NUM_CH*SCALE_W-1:0]   scale_q,
  output logic signed [RATE_W-1:0]    err_o,
  output logic signed [RATE_W-1:0]    rate_o
);

  localparam int MW = RATE_W + 2;
  localparam int PW = RATE_W + SCALE_W;

  logic [REC_W-1:0]          tgt;
  logic signed [RATE_W-1:0]  act;
  logic signed [SCALE_W-1:0] scl;
  logic signed [MW-1:0]      m_tgt;
  logic signed [MW-1:0]      m_fb;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      prod_sh;
  logic signed [63:0]        m_sat;
  logic signed [63:0]        s_sat;
  logic signed [RATE_W-1:0]  m_q;
  logic signed [RATE_W-1:0]  s_q;

  always_comb begin
    tgt   = target_q[idx*REC_W +: REC_W];
    act   = $signed(actual_q[idx*RATE_W +: RATE_W]);
    scl   = $signed(scale_q[idx*SCALE_W +: SCALE_W]);
    m_tgt = $signed({{(MW-REC_W){1'b0}}, tgt} << MAP_SHIFT);
    if (BIPOLAR_MASK[idx]) m_tgt = m_tgt - MW'(MAP_OFFSET);
`ifdef ANGLE_CTRL_DEADBAND_EN
    if (BIPOLAR_MASK[idx] && (m_tgt <= MW'(DEADBAND)) && (m_tgt >= -MW'(DEADBAND))) m_tgt = '0;
`endif
    if (!FB_EN_MASK[idx])      m_fb = m_tgt;
    else if (FB_ADD_MASK[idx]) m_fb = m_tgt + MW'(act);
    else                       m_fb = m_tgt - MW'(act);
    m_sat   = saturate(64'(m_fb), RATE_W);
    // Arithmetic shift floors the product, matching Q-format truncation toward -inf.
    prod    = PW'(m_q) * PW'(scl);
    prod_sh = prod >>> FRAC_W;
    s_sat   = saturate(64'(prod_sh), RATE_W);
  end

  always_comb begin
    rate_o = s_q;
    if (BIPOLAR_MASK[idx]) begin
      if (s_q > RATE_W'(RATE_LIMIT))       rate_o = RATE_W'(RATE_LIMIT);
      else if (s_q < -RATE_W'(RATE_LIMIT)) rate_o = -RATE_W'(RATE_LIMIT);
    end else begin
      if (s_q < 0)                         rate_o = '0;
      else if (s_q > RATE_W'(THR_MAX))     rate_o = RATE_W'(THR_MAX);
    end
  end

  assign err_o = m_q;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (map_en)   m_q <= m_sat[RATE_W-1:0];
      if (scale_en) s_q <= s_sat[RATE_W-1:0];
    end
  end

endmodule

// File: rtl/angle_controller_nch.sv
// rtl/angle_controller_nch.sv - sequential N-channel angle stage: FSM, input snapshot, shadow and output registers
// Optional feature macro: ANGLE_CTRL_DEADBAND_EN (passed through to angle_ctrl_datapath).
module angle_controller_nch
  import angle_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int REC_W      = 8,
  parameter int RATE_W     = 16,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int SCALE_W    = 16,
  parameter int MAP_SHIFT  = 2,
  parameter int MAP_OFFSET = MAP_OFFSET_DEF,
  parameter int RATE_LIMIT = RATE_LIMIT_DEF,
  parameter int THR_MAX    = THR_MAX_DEF,
  parameter logic [NUM_CH-1:0] BIPOLAR_MASK = NUM_CH'(BIPOLAR_MASK_DEF),
  parameter logic [NUM_CH-1:0] FB_EN_MASK   = NUM_CH'(FB_EN_MASK_DEF),
  parameter logic [NUM_CH-1:0] FB_ADD_MASK  = NUM_CH'(FB_ADD_MASK_DEF),
  parameter int DEADBAND   = DEADBAND_DEF
) (
  input  logic                       us_clk,
  input  logic                       resetn,
  input  logic                       start_signal,
  input  logic [NUM_CH*REC_W-1:0]    target_in,
  input  logic [NUM_CH*RATE_W-1:0]   actual_in,
  input  logic [NUM_CH*SCALE_W-1:0]  scale_in,
  output logic [NUM_CH*RATE_W-1:0]   rate_out,
  output logic [NUM_CH*RATE_W-1:0]   angle_error_out,
  output logic                       active_signal,
  output logic                       complete_signal
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [NUM_CH*REC_W-1:0]    tgt_q;
  logic [NUM_CH*RATE_W-1:0]   act_q;
  logic [NUM_CH*SCALE_W-1:0]  scl_q;
  logic [NUM_CH*RATE_W-1:0]   rate_sh_q, rate_sh_d;
  logic [NUM_CH*RATE_W-1:0]   err_sh_q, err_sh_d;
  logic [NUM_CH*RATE_W-1:0]   rate_q, err_q;
  logic                       active_q, complete_q;
  logic signed [RATE_W-1:0]   dp_err, dp_rate;
  logic                       last_ch;

  angle_ctrl_datapath #(
    .NUM_CH(NUM_CH), .REC_W(REC_W), .RATE_W(RATE_W), .FRAC_W(FRAC_W), .SCALE_W(SCALE_W),
    .MAP_SHIFT(MAP_SHIFT), .MAP_OFFSET(MAP_OFFSET), .RATE_LIMIT(RATE_LIMIT), .THR_MAX(THR_MAX),
    .DEADBAND(DEADBAND), .BIPOLAR_MASK(BIPOLAR_MASK), .FB_EN_MASK(FB_EN_MASK),
    .FB_ADD_MASK(FB_ADD_MASK), .IDX_W(IDX_W)
  ) u_datapath (
    .us_clk(us_clk), .resetn(resetn),
    .map_en(state_q == S_MAP), .scale_en(state_q == S_SCALE),
    .idx(idx_q), .target_q(tgt_q), .actual_q(act_q), .scale_q(scl_q),
    .err_o(dp_err), .rate_o(dp_rate)
  );

  assign last_ch = (idx_q == IDX_W'(NUM_CH - 1));

  // The last channel's result is merged here so the full set loads on the edge entering DONE.
  always_comb begin
    rate_sh_d = rate_sh_q;
    err_sh_d  = err_sh_q;
    rate_sh_d[idx_q*RATE_W +: RATE_W] = dp_rate;
    err_sh_d[idx_q*RATE_W +: RATE_W]  = FB_EN_MASK[idx_q] ? dp_err : '0;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tgt_q      <= '0;
      act_q      <= '0;
      scl_q      <= '0;
      rate_sh_q  <= '0;
      err_sh_q   <= '0;
      rate_q     <= '0;
      err_q      <= '0;
      active_q   <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_signal) begin
          tgt_q    <= target_in;
          act_q    <= actual_in;
          scl_q    <= scale_in;
          idx_q    <= '0;
          active_q <= 1'b1;
          state_q  <= S_MAP;
        end
        S_MAP:   state_q <= S_SCALE;
        S_SCALE: state_q <= S_LIMIT;
        S_LIMIT: begin
          rate_sh_q <= rate_sh_d;
          err_sh_q  <= err_sh_d;
          if (last_ch) begin
            rate_q     <= rate_sh_d;
            err_q      <= err_sh_d;
            active_q   <= 1'b0;
            complete_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_MAP;
          end
        end
        S_DONE: begin
          complete_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          active_q   <= 1'b0;
          complete_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign rate_out        = rate_q;
  assign angle_error_out = err_q;
  assign active_signal   = active_q;
  assign complete_signal = complete_q;

endmodule
